// File: rtl/generatore_partita.sv
// Match generator for the rock-paper-scissors FSMD: LFSR-driven move pairs, round/timeout control.
// Optional MANCHE self-check comparator enabled by defining GEN_CONTROLLO_EN.
module generatore_partita #(
    parameter int unsigned MAX_MANCHE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       AVVIA,
    input  logic [7:0] SEME,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic       OCCUPATO,
    output logic       FINE,
    output logic [1:0] ESITO,
    output logic       TIMEOUT,
    output logic [4:0] NUM_MANCHE,
    output logic       ERRORE
);

    localparam int unsigned W_LFSR = 8;
    localparam int unsigned W_NUM  = 5;
    localparam int unsigned W_MOSSA = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_GIOCA,
        S_VALUTA
    } stato_t;

    stato_t               r_state;
    stato_t               w_state_nxt;
    logic [W_LFSR-1:0]    r_lfsr;
    logic [W_LFSR-1:0]    w_lfsr_nxt;
    logic [W_LFSR-1:0]    w_lfsr_step;
    logic [W_MOSSA-1:0]   r_primo;
    logic [W_MOSSA-1:0]   w_primo_nxt;
    logic [W_MOSSA-1:0]   r_secondo;
    logic [W_MOSSA-1:0]   w_secondo_nxt;
    logic                 r_inizia;
    logic                 w_inizia_nxt;
    logic                 r_occupato;
    logic                 w_occupato_nxt;
    logic                 r_fine;
    logic                 w_fine_nxt;
    logic [1:0]           r_esito;
    logic [1:0]           w_esito_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic [W_NUM-1:0]     r_num;
    logic [W_NUM-1:0]     w_num_nxt;
    logic                 w_ultima;

    // Shift left, taps 7/5/4/3 folded into bit 0
    assign w_lfsr_step = {r_lfsr[W_LFSR-2:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_ultima    = (r_num == W_NUM'(MAX_MANCHE));

`ifdef GEN_CONTROLLO_EN
    logic r_errore;
    logic w_errore_nxt;
    logic w_discorde;

    function automatic logic [1:0] manche_attesa(input logic [1:0] p1, input logic [1:0] p2);
        if (p1 == 2'b00 || p2 == 2'b00) begin
            return 2'b00;
        end else if (p1 == p2) begin
            return 2'b11;
        end else if ((p1 == 2'b01 && p2 == 2'b11) ||
                     (p1 == 2'b10 && p2 == 2'b01) ||
                     (p1 == 2'b11 && p2 == 2'b10)) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

    assign w_discorde = (MANCHE != manche_attesa(r_primo, r_secondo));
`else
    logic w_unused_manche;
    assign w_unused_manche = ^MANCHE;
`endif

    // Next-state and next-output computation
    always_comb begin
        w_state_nxt    = r_state;
        w_lfsr_nxt     = r_lfsr;
        w_primo_nxt    = r_primo;
        w_secondo_nxt  = r_secondo;
        w_inizia_nxt   = 1'b0;
        w_fine_nxt     = 1'b0;
        w_occupato_nxt = r_occupato;
        w_esito_nxt    = r_esito;
        w_timeout_nxt  = r_timeout;
        w_num_nxt      = r_num;
`ifdef GEN_CONTROLLO_EN
        w_errore_nxt   = r_errore;
`endif
        if (AVVIA) begin
            w_state_nxt    = S_INIT;
            w_lfsr_nxt     = (SEME == 8'h00) ? 8'h01 : SEME;
            w_primo_nxt    = 2'b00;
            w_secondo_nxt  = 2'b00;
            w_inizia_nxt   = 1'b1;
            w_occupato_nxt = 1'b1;
            w_esito_nxt    = 2'b00;
            w_timeout_nxt  = 1'b0;
            w_num_nxt      = '0;
`ifdef GEN_CONTROLLO_EN
            w_errore_nxt   = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_primo_nxt    = 2'b00;
                    w_secondo_nxt  = 2'b00;
                    w_occupato_nxt = 1'b0;
                end
                S_INIT: begin
                    w_state_nxt   = S_GIOCA;
                    w_primo_nxt   = r_lfsr[1:0];
                    w_secondo_nxt = r_lfsr[3:2];
                    w_num_nxt     = r_num + W_NUM'(1);
                    w_lfsr_nxt    = w_lfsr_step;
                end
                S_GIOCA: begin
                    w_state_nxt = S_VALUTA;
                end
                S_VALUTA: begin
`ifdef GEN_CONTROLLO_EN
                    if (w_discorde) begin
                        w_errore_nxt = 1'b1;
                    end
`endif
                    // A decided match wins over the round limit
                    if (PARTITA != 2'b00) begin
                        w_state_nxt    = S_IDLE;
                        w_esito_nxt    = PARTITA;
                        w_fine_nxt     = 1'b1;
                        w_occupato_nxt = 1'b0;
                        w_primo_nxt    = 2'b00;
                        w_secondo_nxt  = 2'b00;
                    end else if (w_ultima) begin
                        w_state_nxt    = S_IDLE;
                        w_esito_nxt    = 2'b00;
                        w_timeout_nxt  = 1'b1;
                        w_fine_nxt     = 1'b1;
                        w_occupato_nxt = 1'b0;
                        w_primo_nxt    = 2'b00;
                        w_secondo_nxt  = 2'b00;
                    end else begin
                        w_state_nxt   = S_GIOCA;
                        w_primo_nxt   = r_lfsr[1:0];
                        w_secondo_nxt = r_lfsr[3:2];
                        w_num_nxt     = r_num + W_NUM'(1);
                        w_lfsr_nxt    = w_lfsr_step;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= 8'h01;
            r_primo    <= 2'b00;
            r_secondo  <= 2'b00;
            r_inizia   <= 1'b0;
            r_occupato <= 1'b0;
            r_fine     <= 1'b0;
            r_esito    <= 2'b00;
            r_timeout  <= 1'b0;
            r_num      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_primo    <= w_primo_nxt;
            r_secondo  <= w_secondo_nxt;
            r_inizia   <= w_inizia_nxt;
            r_occupato <= w_occupato_nxt;
            r_fine     <= w_fine_nxt;
            r_esito    <= w_esito_nxt;
            r_timeout  <= w_timeout_nxt;
            r_num      <= w_num_nxt;
        end
    end

`ifdef GEN_CONTROLLO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errore <= 1'b0;
        end else begin
            r_errore <= w_errore_nxt;
        end
    end

    assign ERRORE = r_errore;
`else
    assign ERRORE = 1'b0;
`endif

    assign PRIMO      = r_primo;
    assign SECONDO    = r_secondo;
    assign INIZIA     = r_inizia;
    assign OCCUPATO   = r_occupato;
    assign FINE       = r_fine;
    assign ESITO      = r_esito;
    assign TIMEOUT    = r_timeout;
    assign NUM_MANCHE = r_num;

endmodule

// File: tb/tb_generatore_partita.sv
// Bench for generatore_partita: the bench plays the FSMD stub and predicts every output per cycle.
module tb_generatore_partita;

    localparam int unsigned TB_MAX = 4;
`ifdef GEN_CONTROLLO_EN
    localparam bit CTRL = 1'b1;
`else
    localparam bit CTRL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       AVVIA;
    logic [7:0] SEME;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;
    logic       OCCUPATO;
    logic       FINE;
    logic [1:0] ESITO;
    logic       TIMEOUT;
    logic [4:0] NUM_MANCHE;
    logic       ERRORE;

    int   n_vec = 0;
    int   n_err = 0;
    logic m_err;

    generatore_partita #(.MAX_MANCHE(TB_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AVVIA      (AVVIA),
        .SEME       (SEME),
        .PRIMO      (PRIMO),
        .SECONDO    (SECONDO),
        .INIZIA     (INIZIA),
        .MANCHE     (MANCHE),
        .PARTITA    (PARTITA),
        .OCCUPATO   (OCCUPATO),
        .FINE       (FINE),
        .ESITO      (ESITO),
        .TIMEOUT    (TIMEOUT),
        .NUM_MANCHE (NUM_MANCHE),
        .ERRORE     (ERRORE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rock=1, paper=2, scissors=3: difference mod 3 tells the winner
    function automatic logic [1:0] ref_manche(input logic [1:0] a, input logic [1:0] b);
        int d;
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        d = (int'(a) - int'(b) + 3) % 3;
        if (d == 0) return 2'b11;
        if (d == 1) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        logic fb;
        fb = ($countones(x & 8'hB8) % 2) == 1;
        return ((x * 2) % 256) | 8'(fb);
    endfunction

    task automatic exp_out(input string ph, input logic [1:0] p1, input logic [1:0] p2,
                           input logic ini, input logic occ, input logic fin,
                           input logic [1:0] es, input logic tmo, input logic [4:0] num);
        chk($sformatf("%s.PRIMO", ph),      8'(PRIMO),      8'(p1));
        chk($sformatf("%s.SECONDO", ph),    8'(SECONDO),    8'(p2));
        chk($sformatf("%s.INIZIA", ph),     8'(INIZIA),     8'(ini));
        chk($sformatf("%s.OCCUPATO", ph),   8'(OCCUPATO),   8'(occ));
        chk($sformatf("%s.FINE", ph),       8'(FINE),       8'(fin));
        chk($sformatf("%s.ESITO", ph),      8'(ESITO),      8'(es));
        chk($sformatf("%s.TIMEOUT", ph),    8'(TIMEOUT),    8'(tmo));
        chk($sformatf("%s.NUM_MANCHE", ph), 8'(NUM_MANCHE), 8'(num));
        chk($sformatf("%s.ERRORE", ph),     8'(ERRORE),     8'(m_err));
    endtask

    // One match; returns while still in VALUTA of abort_round when that round is reached
    task automatic play_match(input logic [7:0] seed, input int win_round, input logic [1:0] win_res,
                              input int bad_round, input int abort_round);
        logic [7:0] lf;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] em;
        logic       pend;
        string      ph;
        lf    = (seed == 8'h00) ? 8'h01 : seed;
        AVVIA = 1'b1;
        SEME  = seed;
        tick();
        AVVIA   = 1'b0;
        SEME    = 8'($urandom);
        m_err   = 1'b0;
        pend    = 1'b0;
        MANCHE  = 2'($urandom);
        PARTITA = 2'($urandom);
        exp_out($sformatf("init_%02h", seed), 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0);
        for (int r = 1; r <= int'(TB_MAX); r++) begin
            p1 = lf[1:0];
            p2 = lf[3:2];
            lf = lfsr_next(lf);
            tick();
            if (pend) m_err = CTRL;
            pend    = 1'b0;
            MANCHE  = 2'($urandom);
            PARTITA = 2'($urandom);
            ph = $sformatf("gioca_%02h_r%0d", seed, r);
            exp_out(ph, p1, p2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'(r));
            em = ref_manche(p1, p2);
            if (r == bad_round) begin
                MANCHE = (em == 2'b11) ? 2'b01 : (em ^ 2'($urandom_range(1, 3)));
            end else begin
                MANCHE = em;
            end
            PARTITA = (r == win_round) ? win_res : 2'b00;
            tick();
            ph = $sformatf("valuta_%02h_r%0d", seed, r);
            exp_out(ph, p1, p2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'(r));
            if (r == abort_round) return;
            pend = (r == bad_round);
            if (r == win_round || r == int'(TB_MAX)) begin
                tick();
                if (pend) m_err = CTRL;
                MANCHE  = 2'($urandom);
                PARTITA = 2'($urandom);
                ph = $sformatf("fine_%02h", seed);
                if (r == win_round) begin
                    exp_out(ph, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, win_res, 1'b0, 5'(r));
                    tick();
                    exp_out({ph, "_hold"}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, win_res, 1'b0, 5'(r));
                end else begin
                    exp_out(ph, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 5'(r));
                    tick();
                    exp_out({ph, "_hold"}, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'(r));
                end
                return;
            end
        end
    endtask

    initial begin
        int wr;
        int br;
        int ar;
        rst_n   = 1'b0;
        AVVIA   = 1'b0;
        SEME    = 8'h00;
        MANCHE  = 2'b00;
        PARTITA = 2'b00;
        m_err   = 1'b0;
        #12;
        exp_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
        AVVIA = 1'b1;
        SEME  = 8'h21;
        tick();
        exp_out("avvia_in_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
        AVVIA = 1'b0;
        rst_n = 1'b1;
        tick();
        exp_out("post_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);

        play_match(8'h01, 3, 2'b01, 0, 0);
        play_match(8'h5A, 0, 2'b00, 0, 0);
        play_match(8'hC3, int'(TB_MAX), 2'b11, 0, 0);
        play_match(8'h00, 0, 2'b00, 2, 0);
        play_match(8'h37, 0, 2'b00, 1, 2);
        PARTITA = 2'b01;
        MANCHE  = 2'b00;
        play_match(8'h9E, 2, 2'b10, 0, 0);

        AVVIA = 1'b1;
        SEME  = 8'h44;
        tick();
        AVVIA = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        m_err = 1'b0;
        exp_out("reset_gioca", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_out("reset_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0);

        for (int m = 0; m < 24; m++) begin
            wr = $urandom_range(0, TB_MAX);
            br = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, TB_MAX);
            ar = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TB_MAX) : 0;
            play_match(8'($urandom), wr, 2'($urandom_range(1, 3)), br, ar);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/generatore_partita.md
GENERATORE_PARTITA -- requirements
Module: generatore_partita

Interface
REQ-001 Parameter: MAX_MANCHE, default 16, meaning: round limit before timeout; legal range 1..31.
REQ-002 Port: clk  in  1  meaning: single clock, rising edge.
REQ-003 Port: rst_n  in  1  meaning: asynchronous, active-low reset.
REQ-004 Port: AVVIA  in  1  meaning: start or restart match request, sampled at rising edge.
REQ-005 Port: SEME  in  8  meaning: LFSR seed, captured when AVVIA=1.
REQ-006 Port: PRIMO  out  2  meaning: player-1 move to the game FSMD (00 invalid, 01 sasso, 10 carta, 11 forbice).
REQ-007 Port: SECONDO  out  2  meaning: player-2 move, same encoding.
REQ-008 Port: INIZIA  out  1  meaning: game FSMD start/clear strobe.
REQ-009 Port: MANCHE  in  2  meaning: round result from the FSMD (00 invalid, 01 P1, 10 P2, 11 draw).
REQ-010 Port: PARTITA  in  2  meaning: match result from the FSMD (00 ongoing, 01 P1, 10 P2, 11 draw).
REQ-011 Port: OCCUPATO  out  1  meaning: match in progress.
REQ-012 Port: FINE  out  1  meaning: one-cycle end-of-match pulse.
REQ-013 Port: ESITO  out  2  meaning: final PARTITA value, held until next start.
REQ-014 Port: TIMEOUT  out  1  meaning: match ended by MAX_MANCHE, held until next start.
REQ-015 Port: NUM_MANCHE  out  5  meaning: move pairs played in current or last match.
REQ-016 Port: ERRORE  out  1  meaning: sticky MANCHE self-check mismatch.

Function
REQ-017 FSM states SHALL be IDLE, INIT, GIOCA, VALUTA; all outputs are registered.
REQ-018 IDLE: PRIMO=SECONDO=00, INIZIA=0, OCCUPATO=0; AVVIA=1 -> INIT.
REQ-019 In any state, AVVIA=1 SHALL load LFSR with SEME (00 replaced by 01), clear NUM_MANCHE, ESITO, TIMEOUT, ERRORE, and enter INIT.
REQ-020 INIT: INIZIA=1, PRIMO=SECONDO=00 for exactly one cycle, OCCUPATO=1 -> GIOCA.
REQ-021 GIOCA: PRIMO=lfsr[1:0], SECONDO=lfsr[3:2], INIZIA=0; NUM_MANCHE increments; LFSR advances -> VALUTA.
REQ-022 LFSR SHALL shift left, feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] into bit 0.
REQ-023 VALUTA: moves held stable; MANCHE/PARTITA sampled (one-cycle FSMD latency).
REQ-024 VALUTA with PARTITA!=00: ESITO=PARTITA, FINE=1 one cycle -> IDLE.
REQ-025 VALUTA with PARTITA=00 and NUM_MANCHE=MAX_MANCHE: TIMEOUT=1, ESITO=00, FINE=1 -> IDLE.
REQ-026 VALUTA otherwise -> GIOCA; PARTITA!=00 SHALL take priority over timeout in the same cycle.
REQ-027 Expected MANCHE: 00 if either move 00; 11 if equal; else 01 when (P1,P2) is (01,11),(10,01),(11,10), else 10.
REQ-028 NUM_MANCHE SHALL never exceed MAX_MANCHE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, LFSR=01, and all outputs to 0, regardless of state.
REQ-030 Reset release SHALL require a rising edge before any AVVIA takes effect.

Configuration
REQ-031 Macro GEN_CONTROLLO_EN defined: VALUTA compares MANCHE to REQ-027 expectation; any mismatch sets ERRORE, which stays 1 until AVVIA or reset.
REQ-032 Macro GEN_CONTROLLO_EN undefined: no comparator logic; ERRORE is tied to 0.

Verification
REQ-033 Reset: rst_n=0 mid-GIOCA -> all outputs 0 at once, state IDLE.
REQ-034 AVVIA=1, SEME=01 -> next cycle INIZIA=1 for one cycle, then PRIMO=01, SECONDO=00. Stub MANCHE=00 -> ERRORE=0.
REQ-035 Stub returns PARTITA=01 on third VALUTA -> FINE=1 one cycle, ESITO=01, NUM_MANCHE=3, OCCUPATO=0, TIMEOUT=0.
REQ-036 MAX_MANCHE=4, stub PARTITA always 00 -> FINE after fourth VALUTA, TIMEOUT=1, ESITO=00, NUM_MANCHE=4.
REQ-037 Stub MANCHE=01 when expected 11 -> ERRORE=1 and held until next AVVIA (macro on); ERRORE=0 (macro off).
REQ-038 AVVIA=1 during VALUTA -> INIT next cycle, INIZIA=1, NUM_MANCHE=0, first move pair equals seed-derived value.
